sal_ref_ctrl: RTL and testbench

All-bank refresh controller for the DDR controller. It generates periodic refresh demand from a programmable tREFI interval and tracks postponed refreshes. It drives the per-bank refresh request/grant handshake on the bank controllers, and issues one REF command toward the scheduler once every bank has granted. It then holds all banks for tRFC before releasing them.

---
 rtl/sal_ref_ctrl.sv | 137 +++++++++++++
 tb/tb_sal_ref_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sal_ref_ctrl.sv
// All-bank refresh controller: tREFI interval ticks, postponed-refresh count, bank req/gnt, REF issue, tRFC hold.
// Latency: tick at T -> pend_cnt_o at T+1 -> ref_req_o at T+2; full grant at G -> ref_cmd_valid_o at G+1.
// Backpressure: ref_cmd_valid_o holds until ref_cmd_ready_i; partial grants stall REQ indefinitely.
module sal_ref_ctrl #(
  parameter int BK_CNT   = 8,
  parameter int TREFI_W  = 16,
  parameter int TRFC_W   = 10,
  parameter int MAX_PEND = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ref_en_i,
  input  logic [TREFI_W-1:0] t_refi_i,
  input  logic [TRFC_W-1:0]  t_rfc_i,
  output logic [BK_CNT-1:0]  ref_req_o,
  input  logic [BK_CNT-1:0]  ref_gnt_i,
  output logic               ref_cmd_valid_o,
  input  logic               ref_cmd_ready_i,
  output logic               ref_busy_o,
  output logic [3:0]         pend_cnt_o,
  output logic               ref_ovf_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_CMD  = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  localparam logic [3:0] PEND_MAX = 4'(MAX_PEND);

  state_t              state;
  state_t              state_nxt;
  logic [TRFC_W-1:0]   rfc_cnt;
  logic [TRFC_W-1:0]   rfc_nxt;
  logic [TREFI_W-1:0]  ivl_cnt;
  logic                ivl_loaded;
  logic [TREFI_W-1:0]  ivl_reload;
  logic [TREFI_W-1:0]  ivl_eff;
  logic                tick;
  logic                cmd_hs;

  // An interval below 2 would tick every cycle or never; clamp it to 2.
  assign ivl_reload = (t_refi_i < TREFI_W'(2)) ? TREFI_W'(1) : (t_refi_i - TREFI_W'(1));
  // Until the counter has run at least one enabled cycle it reads as the reload value,
  // which keeps the reset value constant while still tracking t_refi_i.
  assign ivl_eff    = ivl_loaded ? ivl_cnt : ivl_reload;
  assign cmd_hs     = ref_cmd_valid_o & ref_cmd_ready_i;

  // Interval counter: count down while enabled, register a one-cycle tick at zero and reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ivl_cnt    <= '0;
      ivl_loaded <= 1'b0;
      tick       <= 1'b0;
    end else if (ref_en_i) begin
      ivl_loaded <= 1'b1;
      tick       <= (ivl_eff == '0);
      ivl_cnt    <= (ivl_eff == '0) ? ivl_reload : (ivl_eff - TREFI_W'(1));
    end else begin
      ivl_loaded <= 1'b0;
      tick       <= 1'b0;
      ivl_cnt    <= ivl_reload;
    end
  end

  // Pending counter: ticks add, REF handshakes remove, saturate at MAX_PEND with a sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_cnt_o <= '0;
      ref_ovf_o  <= 1'b0;
    end else begin
      if (tick && (pend_cnt_o == PEND_MAX)) begin
        ref_ovf_o <= 1'b1;
      end
      if (tick && !cmd_hs && (pend_cnt_o != PEND_MAX)) begin
        pend_cnt_o <= pend_cnt_o + 4'd1;
      end else if (cmd_hs && !tick) begin
        pend_cnt_o <= pend_cnt_o - 4'd1;
      end
    end
  end

  // Next-state logic: IDLE -> REQ on pending work, REQ -> CMD on full grant, CMD -> WAIT on accept, WAIT for tRFC.
  always_comb begin
    state_nxt = state;
    rfc_nxt   = rfc_cnt;
    unique case (state)
      ST_IDLE: begin
        if (pend_cnt_o != '0) begin
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (&ref_gnt_i) begin
          state_nxt = ST_CMD;
        end
      end
      ST_CMD: begin
        if (ref_cmd_ready_i) begin
          state_nxt = ST_WAIT;
          rfc_nxt   = t_rfc_i;
        end
      end
      ST_WAIT: begin
        // A loaded value of 0 or 1 both give a single WAIT cycle.
        if (rfc_cnt <= TRFC_W'(1)) begin
          state_nxt = ST_IDLE;
        end else begin
          rfc_nxt = rfc_cnt - TRFC_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, tRFC counter and outputs registered from the next state so every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      rfc_cnt         <= '0;
      ref_req_o       <= '0;
      ref_cmd_valid_o <= 1'b0;
      ref_busy_o      <= 1'b0;
    end else begin
      state           <= state_nxt;
      rfc_cnt         <= rfc_nxt;
      ref_req_o       <= {BK_CNT{(state_nxt != ST_IDLE)}};
      ref_cmd_valid_o <= (state_nxt == ST_CMD);
      ref_busy_o      <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_sal_ref_ctrl.sv
// Bench for sal_ref_ctrl: table of basic refresh scenarios, hand-built corner sequences,
// then randomized traffic compared cycle by cycle against a behavioural model.
// Cycle 0 is the first cycle with ref_en_i=1 after reset release.
module tb_sal_ref_ctrl;

  localparam int BK   = 8;
  localparam int MAXP = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ref_en_i;
  logic [15:0] t_refi_i;
  logic [9:0]  t_rfc_i;
  logic [7:0]  ref_req_o;
  logic [7:0]  ref_gnt_i;
  logic        ref_cmd_valid_o;
  logic        ref_cmd_ready_i;
  logic        ref_busy_o;
  logic [3:0]  pend_cnt_o;
  logic        ref_ovf_o;

  always #5 clk = ~clk;

  sal_ref_ctrl #(.BK_CNT(BK), .TREFI_W(16), .TRFC_W(10), .MAX_PEND(MAXP)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ref_en_i        (ref_en_i),
    .t_refi_i        (t_refi_i),
    .t_rfc_i         (t_rfc_i),
    .ref_req_o       (ref_req_o),
    .ref_gnt_i       (ref_gnt_i),
    .ref_cmd_valid_o (ref_cmd_valid_o),
    .ref_cmd_ready_i (ref_cmd_ready_i),
    .ref_busy_o      (ref_busy_o),
    .pend_cnt_o      (pend_cnt_o),
    .ref_ovf_o       (ref_ovf_o)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Advance one clock; outputs are then stable for cycle 'cyc'.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reset, program intervals, release reset mid-cycle with refresh enabled: that cycle is cycle 0.
  task automatic start(input int trefi, input int trfc);
    rst_n           = 1'b0;
    ref_en_i        = 1'b0;
    ref_gnt_i       = '0;
    ref_cmd_ready_i = 1'b0;
    t_refi_i        = 16'(trefi);
    t_rfc_i         = 10'(trfc);
    repeat (2) @(posedge clk);
    #2;
    rst_n    = 1'b1;
    ref_en_i = 1'b1;
    cyc      = 0;
  endtask

  // ---------------- behavioural reference model ----------------
  localparam int P_IDLE = 0, P_REQ = 1, P_CMD = 2, P_WAIT = 3;
  int m_cyc, m_en_cnt, m_pend, m_phase, m_wait_end;
  bit m_tick, m_ovf;

  task automatic model_reset();
    m_cyc = 0; m_en_cnt = 0; m_pend = 0; m_phase = P_IDLE; m_wait_end = 0;
    m_tick = 1'b0; m_ovf = 1'b0;
  endtask

  // Apply one clock edge given the inputs that were present during the cycle just ended.
  task automatic model_edge(input bit en, input int trefi, input int trfc, input logic [7:0] gnt, input bit rdy);
    int  r;
    bit  hs;
    bit  tk;
    int  old_pend;
    r        = (trefi < 2) ? 2 : trefi;
    hs       = (m_phase == P_CMD) && rdy;
    tk       = m_tick;
    old_pend = m_pend;
    // A tick is seen every r-th consecutive enabled cycle, one cycle later.
    if (en) begin
      m_en_cnt++;
      m_tick = ((m_en_cnt % r) == 0);
    end else begin
      m_en_cnt = 0;
      m_tick   = 1'b0;
    end
    if (tk && old_pend == MAXP) m_ovf = 1'b1;
    if (tk && !hs && old_pend < MAXP) m_pend = old_pend + 1;
    else if (hs && !tk) m_pend = old_pend - 1;
    case (m_phase)
      P_IDLE: if (old_pend > 0) m_phase = P_REQ;
      P_REQ:  if (gnt == 8'hFF) m_phase = P_CMD;
      P_CMD:  if (rdy) begin
                m_phase    = P_WAIT;
                m_wait_end = m_cyc + ((trfc < 1) ? 1 : trfc);
              end
      default: if (m_cyc == m_wait_end) m_phase = P_IDLE;
    endcase
    m_cyc++;
  endtask

  function automatic logic [14:0] model_out();
    logic [7:0] rq;
    rq = (m_phase != P_IDLE) ? 8'hFF : 8'h00;
    return {rq, (m_phase == P_CMD), (m_phase != P_IDLE), 4'(m_pend), m_ovf};
  endfunction

  // ---------------- scenario table ----------------
  typedef struct {
    int t_refi;
    int t_rfc;
    int exp_req_cyc;   // first cycle ref_req_o is high
    int exp_drop_off;  // cycles from handshake to ref_req_o low
    int exp_pend_end;  // pend_cnt_o on the drop cycle
  } vec_t;

  vec_t vecs[5];

  initial begin
    int req_cyc, hs_cyc, drop_cyc, n_hs, pend_end;
    logic [7:0] req_at_rise;
    bit saw;
    int v17, o18, o19, maxp;

    vecs[0] = '{t_refi: 100, t_rfc: 20, exp_req_cyc: 102, exp_drop_off: 21, exp_pend_end: 0};
    vecs[1] = '{t_refi: 40,  t_rfc: 0,  exp_req_cyc: 42,  exp_drop_off: 2,  exp_pend_end: 0};
    vecs[2] = '{t_refi: 0,   t_rfc: 1,  exp_req_cyc: 4,   exp_drop_off: 2,  exp_pend_end: 3};
    vecs[3] = '{t_refi: 1,   t_rfc: 3,  exp_req_cyc: 4,   exp_drop_off: 4,  exp_pend_end: 4};
    vecs[4] = '{t_refi: 37,  t_rfc: 9,  exp_req_cyc: 39,  exp_drop_off: 10, exp_pend_end: 0};

    // Reset state.
    rst_n = 1'b0; ref_en_i = 1'b0; ref_gnt_i = '0; ref_cmd_ready_i = 1'b0;
    t_refi_i = 16'd100; t_rfc_i = 10'd20;
    #1;
    chk("rst_req",   ref_req_o, 8'h00);
    chk("rst_valid", ref_cmd_valid_o, 1'b0);
    chk("rst_busy",  ref_busy_o, 1'b0);
    chk("rst_pend",  pend_cnt_o, 4'd0);
    chk("rst_ovf",   ref_ovf_o, 1'b0);

    // Basic refresh table: grants 3 cycles after request, ready always.
    for (int v = 0; v < 5; v++) begin
      start(vecs[v].t_refi, vecs[v].t_rfc);
      ref_cmd_ready_i = 1'b1;
      req_cyc = -1; hs_cyc = -1; drop_cyc = -1; n_hs = 0; pend_end = -1; req_at_rise = '0;
      for (int k = 0; k < 400 && drop_cyc < 0; k++) begin
        step();
        if (req_cyc < 0 && ref_req_o != 0) begin
          req_cyc = cyc; req_at_rise = ref_req_o;
        end
        if (hs_cyc >= 0 && ref_req_o == 0) begin
          drop_cyc = cyc; pend_end = pend_cnt_o;
        end
        ref_gnt_i = (req_cyc >= 0 && cyc >= req_cyc + 3 && ref_req_o != 0) ? 8'hFF : 8'h00;
        if (drop_cyc < 0 && ref_cmd_valid_o && ref_cmd_ready_i) begin
          n_hs++;
          if (hs_cyc < 0) hs_cyc = cyc;
        end
      end
      chk($sformatf("tbl%0d_req_cycle", v), req_cyc, vecs[v].exp_req_cyc);
      chk($sformatf("tbl%0d_req_value", v), req_at_rise, 8'hFF);
      chk($sformatf("tbl%0d_hs_count", v), n_hs, 1);
      chk($sformatf("tbl%0d_drop_off", v), drop_cyc - hs_cyc, vecs[v].exp_drop_off);
      chk($sformatf("tbl%0d_pend_end", v), pend_end, vecs[v].exp_pend_end);
    end

    // Partial grant: 0x7F for 50 cycles must not issue REF; 0xFF issues it one cycle later.
    start(100, 5);
    for (int k = 0; k < 200 && ref_req_o == 0; k++) step();
    chk("pg_req_cycle", cyc, 102);
    saw = 1'b0;
    for (int k = 0; k < 50; k++) begin
      ref_gnt_i = 8'h7F;
      step();
      if (ref_cmd_valid_o) saw = 1'b1;
    end
    chk("pg_no_valid_partial", saw, 1'b0);
    chk("pg_req_held", ref_req_o, 8'hFF);
    ref_gnt_i = 8'hFF;
    step();
    chk("pg_valid_after_full", ref_cmd_valid_o, 1'b1);
    saw = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (!ref_cmd_valid_o) saw = 1'b1;
    end
    chk("pg_valid_held_no_ready", saw, 1'b0);

    // Postponement: four ticks accumulate, then drain with refresh disabled.
    start(10, 1);
    while (cyc < 45) step();
    chk("pp_pend_4", pend_cnt_o, 4'd4);
    ref_en_i = 1'b0;
    ref_cmd_ready_i = 1'b1;
    n_hs = 0;
    for (int k = 0; k < 200 && !(pend_cnt_o == 0 && !ref_busy_o); k++) begin
      ref_gnt_i = (ref_req_o != 0) ? 8'hFF : 8'h00;
      if (ref_cmd_valid_o) n_hs++;
      step();
    end
    chk("pp_hs_count", n_hs, 4);
    chk("pp_idle_cycle", cyc, 60);
    repeat (15) step();
    chk("pp_pend_end", pend_cnt_o, 4'd0);

    // Saturation: ticks every 2 cycles with no grants.
    start(2, 4);
    v17 = -1; o18 = -1; o19 = -1; maxp = 0;
    while (cyc < 60) begin
      step();
      if (pend_cnt_o > maxp) maxp = pend_cnt_o;
      if (cyc == 17) v17 = pend_cnt_o;
      if (cyc == 18) o18 = ref_ovf_o;
      if (cyc == 19) o19 = ref_ovf_o;
    end
    chk("sat_pend_17", v17, 8);
    chk("sat_ovf_18", o18, 0);
    chk("sat_ovf_19", o19, 1);
    chk("sat_pend_max", maxp, 8);
    chk("sat_ovf_sticky", ref_ovf_o, 1'b1);

    // Tick and handshake in the same cycle at pend=1.
    start(20, 2);
    saw = 1'b0;
    while (cyc < 45) begin
      step();
      if (cyc >= 23 && cyc <= 40 && !ref_cmd_valid_o) saw = 1'b1;
      if (cyc == 40) chk("sim_pend_40", pend_cnt_o, 4'd1);
      if (cyc == 41) chk("sim_pend_41", pend_cnt_o, 4'd1);
      if (cyc == 42) chk("sim_req_wait", ref_req_o, 8'hFF);
      if (cyc == 43) chk("sim_req_drop", {ref_req_o, ref_busy_o}, 9'h000);
      if (cyc == 44) chk("sim_req_again", ref_req_o, 8'hFF);
      ref_gnt_i = (ref_req_o != 0) ? 8'hFF : 8'h00;
      ref_cmd_ready_i = (cyc == 40);
    end
    chk("sim_valid_held", saw, 1'b0);

    // Reset during WAIT with a refresh pending.
    start(30, 40);
    ref_cmd_ready_i = 1'b1;
    while (cyc < 65) begin
      ref_gnt_i = (ref_req_o != 0) ? 8'hFF : 8'h00;
      step();
    end
    chk("rw_busy_before", {ref_busy_o, ref_cmd_valid_o, pend_cnt_o}, {1'b1, 1'b0, 4'd1});
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_async_clear", {ref_req_o, ref_busy_o, ref_cmd_valid_o, pend_cnt_o}, 14'h0);
    ref_gnt_i = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc = 0;
    while (cyc < 32) begin
      step();
      if (cyc == 30) chk("rw_pend_30", pend_cnt_o, 4'd0);
      if (cyc == 31) chk("rw_pend_31", pend_cnt_o, 4'd1);
      if (cyc == 32) chk("rw_req_32", ref_req_o, 8'hFF);
    end

    // Randomized traffic against the model: compliant banks, random ready, occasional disable.
    for (int seg = 0; seg < 8; seg++) begin
      int trefi, trfc;
      bit en_s, rdy_s;
      logic [7:0] gnt_s;
      trefi = $urandom_range(0, 24);
      trfc  = $urandom_range(0, 12);
      start(trefi, trfc);
      model_reset();
      en_s = 1'b1;
      for (int k = 0; k < 1200; k++) begin
        if (k > 0) begin
          if (en_s && $urandom_range(0, 199) == 0) en_s = 1'b0;
          else if (!en_s && $urandom_range(0, 19) == 0) en_s = 1'b1;
        end
        rdy_s = ($urandom_range(0, 1) == 1);
        gnt_s = ref_gnt_i;
        for (int b = 0; b < BK; b++) begin
          if (ref_req_o[b]) gnt_s[b] = gnt_s[b] | ($urandom_range(0, 2) == 0);
          else              gnt_s[b] = 1'b0;
        end
        ref_en_i = en_s; ref_cmd_ready_i = rdy_s; ref_gnt_i = gnt_s;
        step();
        model_edge(en_s, trefi, trfc, gnt_s, rdy_s);
        chk($sformatf("rand_s%0d_out", seg),
            {ref_req_o, ref_cmd_valid_o, ref_busy_o, pend_cnt_o, ref_ovf_o}, model_out());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
